// File: rtl/dff_rst_bank_if.sv
// dff_rst_bank_if: load/data/observation signals of one dff_rst_bank.
// The master side drives load enable and data; the slave side (the bank)
// returns the registered value, its one-cycle-delayed copy and the change
// strobe. The parity output exists only when DFF_RST_BANK_PARITY_EN is defined.
interface dff_rst_bank_if #(
    parameter int WIDTH = 4
);
    logic             i_en;
    logic [WIDTH-1:0] i_d;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_q_d1;
    logic             o_chg;
`ifdef DFF_RST_BANK_PARITY_EN
    logic             o_par;

    modport master (
        output i_en,
        output i_d,
        input  o_q,
        input  o_q_d1,
        input  o_chg,
        input  o_par
    );

    modport slave (
        input  i_en,
        input  i_d,
        output o_q,
        output o_q_d1,
        output o_chg,
        output o_par
    );
`else
    modport master (
        output i_en,
        output i_d,
        input  o_q,
        input  o_q_d1,
        input  o_chg
    );

    modport slave (
        input  i_en,
        input  i_d,
        output o_q,
        output o_q_d1,
        output o_chg
    );
`endif
endinterface

// File: rtl/dff_rst_bank.sv
// dff_rst_bank: WIDTH-bit register bank with synchronous active-high reset,
// load enable, a one-cycle-delayed copy of the stored value and a registered
// change-detect strobe.
// Optional feature macro: DFF_RST_BANK_PARITY_EN adds o_par, the even parity
// (XOR reduction) of the stored value, decoded straight from the register.
// Edge priority: i_rst > i_en > hold. The delayed copy shifts on every
// non-reset edge, whether or not a load happens.
// The interface instance must be built with the same WIDTH as this module.
module dff_rst_bank #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic          i_clk,
    input  logic          i_rst,
    dff_rst_bank_if.slave bif
);

`ifdef DFF_RST_BANK_PARITY_EN
    // Even parity of a register word: 1 when an odd number of bits are set.
    function automatic logic even_parity(input logic [WIDTH-1:0] value);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc ^ value[i];
        end
        return acc;
    endfunction
`endif

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d1_d;
    logic [WIDTH-1:0] data_d1_q;
    logic             chg_d;
    logic             chg_q;

    // Next-state: load on enable and flag a change, otherwise hold; the
    // delayed copy always takes the current stored value.
    always_comb begin
        data_d    = data_q;
        data_d1_d = data_q;
        chg_d     = 1'b0;
        if (bif.i_en) begin
            data_d = bif.i_d;
            chg_d  = (bif.i_d != data_q);
        end else begin
            data_d = data_q;
            chg_d  = 1'b0;
        end
    end

    // State registers; reset wins over any load and clears the strobe even
    // when RST_VAL differs from the value being discarded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q    <= RST_VAL;
            data_d1_q <= RST_VAL;
            chg_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            data_d1_q <= data_d1_d;
            chg_q     <= chg_d;
        end
    end

    assign bif.o_q    = data_q;
    assign bif.o_q_d1 = data_d1_q;
    assign bif.o_chg  = chg_q;

`ifdef DFF_RST_BANK_PARITY_EN
    assign bif.o_par  = even_parity(data_q);
`endif

endmodule

// File: tb/tb_dff_rst_bank.sv
// tb_dff_rst_bank: scoreboard bench for dff_rst_bank. A reference model
// samples the inputs at every rising edge and queues the expected outputs;
// an independent monitor pops and compares on every falling edge.
module tb_dff_rst_bank;

    localparam int W = 4;
`ifdef DFF_RST_BANK_PARITY_EN
    localparam logic [W-1:0] RST = 4'h1;
`else
    localparam logic [W-1:0] RST = 4'h0;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] d1;
        logic         chg;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_checks;
    int   n_pass;
    bit   done;

    dff_rst_bank_if #(.WIDTH(W)) bif ();

    dff_rst_bank #(.WIDTH(W), .RST_VAL(RST)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bif   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stored value is whatever was last loaded (or the
    // reset value), the delayed copy is the stored value one edge earlier, and
    // the strobe says whether this edge altered the stored value.
    initial begin : model
        logic [W-1:0] m_q;
        logic [W-1:0] m_prev;
        logic         m_chg;
        logic [W-1:0] nxt;
        bit           known;
        known = 1'b0;
        m_q = '0; m_prev = '0; m_chg = 1'b0;
        forever begin
            @(posedge clk);
            if (rst === 1'b1) begin
                m_q = RST; m_prev = RST; m_chg = 1'b0; known = 1'b1;
            end else if (known) begin
                nxt    = (bif.i_en === 1'b1) ? bif.i_d : m_q;
                m_chg  = (nxt != m_q);
                m_prev = m_q;
                m_q    = nxt;
            end
            if (known) sb.push_back('{q: m_q, d1: m_prev, chg: m_chg});
        end
    end

    // Monitor: the bank presents a new result every cycle; compare it mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("o_q",    64'(bif.o_q),    64'(e.q));
            check("o_q_d1", 64'(bif.o_q_d1), 64'(e.d1));
            check("o_chg",  64'(bif.o_chg),  64'(e.chg));
`ifdef DFF_RST_BANK_PARITY_EN
            check("o_par",  64'(bif.o_par),  64'(^e.q));
`endif
        end
    end

    // Apply one cycle of stimulus: data/enable then reset at random offsets
    // after the rising edge, both settled well before the next edge.
    task automatic drive(input logic r, input logic e, input logic [W-1:0] d);
        int a;
        int b;
        @(posedge clk);
        a = $urandom_range(1, 4);
        b = $urandom_range(1, 4);
        #a;
        bif.i_en = e;
        bif.i_d  = d;
        #b;
        rst = r;
    endtask

    initial begin : stim
        rst = 1'b0; bif.i_en = 1'b0; bif.i_d = '0;
        n_checks = 0; n_pass = 0; done = 1'b0;
        // Reset hold with a load attempt pending.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'hA);
        // Release and load, then reload the same value.
        drive(1'b0, 1'b1, 4'h5);
        drive(1'b0, 1'b1, 4'h5);
        // Enable gating.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'hF);
        // Narrow reset pulse between edges must be ignored.
        @(posedge clk);
        #3 rst = 1'b1;
        #3 rst = 1'b0;
        bif.i_en = 1'b1; bif.i_d = 4'h7;
        drive(1'b0, 1'b1, 4'h5);
        // Reset held across an edge while data would have changed.
        drive(1'b1, 1'b1, 4'h3);
        drive(1'b0, 1'b1, 4'hC);
        drive(1'b0, 1'b0, 4'h0);
        // Random stress.
        for (int i = 0; i < 100; i++) begin
            drive(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 4'($urandom));
        end
        drive(1'b0, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
        end
    end

endmodule
